// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed big-endian data memory with wait states, fault decode and reset sweep
module dmem_ctrl #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        busy_clear
);
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] clr_ptr;
    logic [3:0]    wait_cnt;
    logic          lat_we, lat_unsigned;
    logic [1:0]    lat_size;
    logic [31:0]   lat_addr;
    logic          accept;
    logic          cur_we, cur_unsigned;
    logic [1:0]    cur_size;
    logic [31:0]   cur_addr;
    logic [32:0]   diff;
    logic [32:0]   end_off;
    logic [2:0]    nbytes;
    logic          fault;
    logic [AW-1:0] idx;
    logic [7:0]    b0, b1, b2, b3;
    logic          ext;
    logic [31:0]   load_data;

    assign accept = req_valid && req_ready;

    // In IDLE the live request is decoded, so stores and zero-wait loads act on the accept edge.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we       = req_we;
            cur_unsigned = req_unsigned;
            cur_size     = req_size;
            cur_addr     = req_addr;
        end else begin
            cur_we       = lat_we;
            cur_unsigned = lat_unsigned;
            cur_size     = lat_size;
            cur_addr     = lat_addr;
        end
    end

    // The borrow of the 33-bit subtract flags addresses below the window; the 33-bit end never wraps.
    always_comb begin
        case (cur_size)
            SIZE_B:  nbytes = 3'd1;
            SIZE_H:  nbytes = 3'd2;
            SIZE_W:  nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        diff    = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
        end_off = {1'b0, diff[31:0]} + 33'(nbytes);
        fault   = (nbytes == 3'd0)
               || (cur_size == SIZE_H && cur_addr[0])
               || (cur_size == SIZE_W && cur_addr[1:0] != 2'b00)
               || diff[32]
               || (end_off > 33'(DEPTH_BYTES));
        idx     = diff[AW-1:0];
    end

    assign b0 = mem[idx];
    assign b1 = mem[idx + AW'(1)];
    assign b2 = mem[idx + AW'(2)];
    assign b3 = mem[idx + AW'(3)];

    always_comb begin
        ext = !cur_unsigned && b0[7];
        case (cur_size)
            SIZE_B:  load_data = {{24{ext}}, b0};
            SIZE_H:  load_data = {{16{ext}}, b0, b1};
            SIZE_W:  load_data = {b0, b1, b2, b3};
            default: load_data = 32'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_CLEAR: if (clr_ptr == CLR_LAST) state_n = S_IDLE;
            S_IDLE:  if (req_valid) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_CLEAR;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        busy_clear = (state == S_CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            clr_ptr      <= '0;
            wait_cnt     <= 4'd0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= 32'd0;
            resp_rdata   <= 32'd0;
            resp_fault   <= 1'b0;
        end else begin
            if (state == S_CLEAR) clr_ptr <= clr_ptr + AW'(4);
            if (accept) begin
                lat_we       <= req_we;
                lat_unsigned <= req_unsigned;
                lat_size     <= req_size;
                lat_addr     <= req_addr;
                wait_cnt     <= 4'(WAIT_STATES - 1);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state_n == S_RESP) begin
                resp_fault <= fault;
                resp_rdata <= (fault || cur_we) ? 32'd0 : load_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[clr_ptr]          <= 8'd0;
                mem[clr_ptr + AW'(1)] <= 8'd0;
                mem[clr_ptr + AW'(2)] <= 8'd0;
                mem[clr_ptr + AW'(3)] <= 8'd0;
            end else if (accept && cur_we && !fault) begin
                case (cur_size)
                    SIZE_B: mem[idx] <= req_wdata[7:0];
                    SIZE_H: begin
                        mem[idx]          <= req_wdata[15:8];
                        mem[idx + AW'(1)] <= req_wdata[7:0];
                    end
                    SIZE_W: begin
                        mem[idx]          <= req_wdata[31:24];
                        mem[idx + AW'(1)] <= req_wdata[23:16];
                        mem[idx + AW'(2)] <= req_wdata[15:8];
                        mem[idx + AW'(3)] <= req_wdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed and randomized checks of dmem_ctrl against a byte-array model
module tb_dmem_ctrl;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [1:0]  SB = 2'd0, SH = 2'd1, SW = 2'd2;

    logic        CLK = 1'b0;
    logic        rst [2];
    logic        vld [2];
    logic        rdy [2];
    logic        rv [2];
    logic        flt [2];
    logic        busy [2];
    logic [31:0] rdata [2];
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  mdl [2][DEPTH];
    bit          armed [2];
    bit          pend [2];
    int          due [2], blk_end [2], busy_end [2];
    logic [31:0] exp_data [2], last_data [2];
    bit          exp_flt [2], last_flt [2];

    dmem_ctrl #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
        .CLK(CLK), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_fault(flt[0]), .busy_clear(busy[0]));

    dmem_ctrl #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u1 (
        .CLK(CLK), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_fault(flt[1]), .busy_clear(busy[1]));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int ws(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Architectural effect of one access on the model array: fault rule, big-endian bytes, extension.
    function automatic void model_access(int i, bit w, logic [1:0] sz, bit u, logic [31:0] a,
                                         logic [31:0] wd, output logic [31:0] d, output bit f);
        int     n;
        longint off, val;
        n   = (sz == SB) ? 1 : (sz == SH) ? 2 : (sz == SW) ? 4 : 0;
        off = longint'(a) - longint'(BASE);
        d   = 32'd0;
        if (n == 0) f = 1'b1;
        else f = ((a % n) != 0) || (off < 0) || (off + n > DEPTH);
        if (f) return;
        if (w) begin
            for (int k = 0; k < n; k++) mdl[i][off + k] = 8'(wd >> (8 * (n - 1 - k)));
            return;
        end
        val = 0;
        for (int k = 0; k < n; k++) val = val * 256 + longint'(mdl[i][off + k]);
        if (!u && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
        d = val[31:0];
    endfunction

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            bit e_busy, e_rdy, e_rv;
            e_busy = (cyc <= busy_end[i]);
            e_rdy  = !e_busy && (cyc > blk_end[i]);
            e_rv   = pend[i] && (cyc == due[i]);
            if (e_rv) begin
                last_data[i] = exp_data[i];
                last_flt[i]  = exp_flt[i];
                pend[i]      = 1'b0;
            end
            if (armed[i]) begin
                check($sformatf("busy_clear[%0d]", i), 32'(busy[i]), 32'(e_busy));
                check($sformatf("req_ready[%0d]", i), 32'(rdy[i]), 32'(e_rdy));
                check($sformatf("resp_valid[%0d]", i), 32'(rv[i]), 32'(e_rv));
                check($sformatf("resp_rdata[%0d]", i), rdata[i], last_data[i]);
                check($sformatf("resp_fault[%0d]", i), 32'(flt[i]), 32'(last_flt[i]));
            end
            if (rst[i]) begin
                armed[i]     = 1'b1;
                pend[i]      = 1'b0;
                busy_end[i]  = cyc + DEPTH / 4;
                blk_end[i]   = cyc;
                last_data[i] = 32'd0;
                last_flt[i]  = 1'b0;
                for (int j = 0; j < DEPTH; j++) mdl[i][j] = 8'h00;
            end else if (armed[i] && e_rdy && vld[i]) begin
                model_access(i, we, size, uns, addr, wdata, exp_data[i], exp_flt[i]);
                pend[i]    = 1'b1;
                due[i]     = cyc + 1 + ws(i);
                blk_end[i] = due[i];
            end
        end
    end

    task automatic do_req(int i, bit w, logic [1:0] sz, bit u, logic [31:0] a, logic [31:0] wd,
                          bit hold, output logic [31:0] d, output bit f, output int lat);
        int acc, n;
        @(posedge CLK); #2;
        we = w; size = sz; uns = u; addr = a; wdata = wd; vld[i] = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!rdy[i] && n < 2000);
        check("accept_seen", 32'(rdy[i]), 32'd1);
        acc = cyc;
        if (!hold) begin @(posedge CLK); #2; vld[i] = 1'b0; end
        n = 0;
        do begin @(negedge CLK); n++; end while (!rv[i] && n < 40);
        check("resp_seen", 32'(rv[i]), 32'd1);
        d = rdata[i]; f = flt[i]; lat = cyc - acc;
        if (hold) begin @(posedge CLK); #2; vld[i] = 1'b0; end
    endtask

    task automatic pulse_reset(int i);
        @(posedge CLK); #2; rst[i] = 1'b1;
        @(posedge CLK); #2; rst[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a;
        bit          f, w;
        int          lat, n, seen, r, nb;
        logic [1:0]  sz;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; armed[i] = 1'b0; pend[i] = 1'b0;
        end
        we = 1'b0; uns = 1'b0; size = SW; addr = BASE; wdata = 32'd0;
        repeat (3) @(posedge CLK);
        #2; rst[0] = 1'b0; rst[1] = 1'b0;

        // Sweep after a reset erases earlier stores and lasts DEPTH/4 cycles.
        do_req(1, 1, SW, 0, BASE + 32'h10, 32'h1122_3344, 0, d, f, lat);
        pulse_reset(1);
        n = 0;
        @(negedge CLK);
        while (busy[1] && n < 1000) begin n++; @(negedge CLK); end
        check("t1_busy_cycles", 32'(n), 32'd64);
        do_req(1, 0, SW, 0, BASE + 32'h10, 32'd0, 0, d, f, lat);
        check("t1_load_after_clear", d, 32'h0);

        for (int i = 0; i < 2; i++) begin
            do_req(i, 1, SW, 0, BASE + 32'h20, 32'hDEAD_BEEF, 0, d, f, lat);
            check("t2_store_rdata", d, 32'h0);
            do_req(i, 0, SB, 0, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t2_lb_signed", d, 32'hFFFF_FFDE);
            do_req(i, 0, SB, 1, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t2_lb_unsigned", d, 32'h0000_00DE);
            do_req(i, 0, SH, 0, BASE + 32'h22, 32'd0, 0, d, f, lat);
            check("t2_lh_signed", d, 32'hFFFF_BEEF);
            do_req(i, 0, SH, 1, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t2_lh_unsigned", d, 32'h0000_DEAD);
            check("t2_latency", 32'(lat), 32'(1 + ws(i)));
            do_req(i, 1, SB, 0, BASE + 32'h21, 32'h0000_005A, 0, d, f, lat);
            do_req(i, 1, SH, 0, BASE + 32'h22, 32'h0000_0102, 0, d, f, lat);
            do_req(i, 0, SW, 0, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t3_merge", d, 32'hDE5A_0102);
            do_req(i, 1, SW, 0, BASE + 32'h22, 32'hCAFE_F00D, 0, d, f, lat);
            check("t4_misaligned_fault", 32'(f), 32'd1);
            do_req(i, 0, 2'b11, 0, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t4_badsize_fault", 32'(f), 32'd1);
            check("t4_badsize_rdata", d, 32'h0);
            do_req(i, 0, SW, 0, BASE + DEPTH - 2, 32'd0, 0, d, f, lat);
            check("t4_end_fault", 32'(f), 32'd1);
            do_req(i, 1, SW, 0, BASE - 4, 32'h5555_5555, 0, d, f, lat);
            check("t4_below_fault", 32'(f), 32'd1);
            do_req(i, 0, SW, 0, 32'hFFFF_FFFC, 32'd0, 0, d, f, lat);
            check("t4_wrap_fault", 32'(f), 32'd1);
            do_req(i, 0, SW, 0, BASE + DEPTH - 4, 32'd0, 0, d, f, lat);
            check("t4_last_word_ok", 32'(f), 32'd0);
            do_req(i, 0, SW, 0, BASE + 32'h20, 32'd0, 0, d, f, lat);
            check("t4_unchanged", d, 32'hDE5A_0102);
        end

        // Request held through WAIT yields one response; ready returns the cycle after.
        do_req(1, 0, SW, 0, BASE + 32'h20, 32'd0, 1, d, f, lat);
        check("t5_latency", 32'(lat), 32'd4);
        @(negedge CLK);
        check("t5_ready_after", 32'(rdy[1]), 32'd1);
        seen = 0;
        repeat (6) begin @(negedge CLK); if (rv[1]) seen++; end
        check("t5_single_resp", 32'(seen), 32'd0);

        // Reset two cycles after a load accept abandons the load and restarts the sweep.
        @(posedge CLK); #2;
        we = 1'b0; size = SW; uns = 1'b0; addr = BASE + 32'h20; vld[1] = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!rdy[1] && n < 2000);
        @(posedge CLK); #2; vld[1] = 1'b0;
        @(posedge CLK); #2; rst[1] = 1'b1;
        @(posedge CLK); #2; rst[1] = 1'b0;
        seen = 0;
        @(negedge CLK);
        check("t6_busy_rises", 32'(busy[1]), 32'd1);
        repeat (8) begin if (rv[1]) seen++; @(negedge CLK); end
        check("t6_no_resp", 32'(seen), 32'd0);
        do_req(1, 0, SW, 0, BASE + 32'h20, 32'd0, 0, d, f, lat);
        check("t6_cleared", d, 32'h0);

        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 150; t++) begin
                w  = 1'($urandom_range(0, 1));
                sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                r  = $urandom_range(0, 15);
                if (r == 0)      a = $urandom();
                else if (r == 1) a = BASE - 32'($urandom_range(1, 8));
                else if (r == 2) a = BASE + DEPTH - 8 + 32'($urandom_range(0, 15));
                else             a = BASE + 32'($urandom_range(0, 47));
                nb = (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
                if (r > 4) a = a & ~32'(nb - 1);
                do_req(i, w, sz, 1'($urandom_range(0, 1)), a, $urandom(), 0, d, f, lat);
                if ($urandom_range(0, 49) == 0) pulse_reset(i);
            end
        end

        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
